seq_detect_ctrl: RTL and testbench

//  Programmable serial pattern-detection controller.
//  - Holds a configurable bit pattern (1..MAX_LEN bits) and scans a qualified serial stream x.
//  - Counts matches, in overlapping or non-overlapping mode, and stops after a programmed limit.
//  - Sits between the configuration bus and the serial front end; replaces fixed-pattern detectors.

---
 rtl/seq_ctrl_pkg.sv | 17 +
 rtl/seq_window_cmp.sv | 63 ++++++
 rtl/seq_detect_ctrl.sv | 145 ++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared types and default sizing for the serial pattern-detection controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_ctrl_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_LEN_W   = $clog2(DEF_MAX_LEN) + 1;

    // Controller states: IDLE accepts configuration, SCAN consumes bits, DONE holds the count.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_window_cmp.sv
// Shift window of the most recent serial bits with a fill count and a length-masked compare.
// Latency: hit is combinational on the window value that the current shift will produce.
// Backpressure: none; shift is a qualifier, every qualified bit is consumed.
module seq_window_cmp #(
    parameter  int MAX_LEN = 8,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift,
    input  logic               clr,
    input  logic               x,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_LEN-1:0] win;
    logic [MAX_LEN-1:0] win_nxt;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_nxt;
    logic               eq;

    // Next window: newest bit enters at bit 0, fill saturates at the window depth.
    always_comb begin
        win_nxt  = win;
        fill_nxt = fill;
        if (shift) begin
            win_nxt = {win[MAX_LEN-2:0], x};
            if (fill != LEN_W'(MAX_LEN)) begin
                fill_nxt = fill + 1'b1;
            end
        end
    end

    // Compare only the low len bits of the updated window against the pattern.
    always_comb begin
        eq = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(len)) && (win_nxt[i] != pattern[i])) begin
                eq = 1'b0;
            end
        end
    end

    // A hit needs a fresh bit and enough history to cover the whole pattern.
    assign hit = shift && (fill_nxt >= len) && eq;

    // Window state; clr wins over shift so a non-overlapping hit restarts the fill from zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            win  <= '0;
            fill <= '0;
        end else if (clr) begin
            win  <= '0;
            fill <= '0;
        end else begin
            win  <= win_nxt;
            fill <= fill_nxt;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: config registers, scan FSM, match counter with limit.
// Latency: match pulses the cycle after the edge that samples the completing bit; done follows the limit hit by one edge.
// Backpressure: none; x is consumed whenever x_valid is high in SCAN, ignored elsewhere.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter  int MAX_LEN = DEF_MAX_LEN,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_limit,
    output logic               cfg_err,
    input  logic               start,
    input  logic               abort,
    input  logic               x_valid,
    input  logic               x,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
);

    state_t             state;
    state_t             state_nxt;

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   lim_q;

    logic [CNT_W-1:0]   cnt_nxt;
    logic               match_nxt;
    logic               cfg_ok;
    logic               err_nxt;
    logic               shift;
    logic               clr;
    logic               hit;

    // Configuration is only taken while idle and with a length the window can hold.
    assign cfg_ok  = cfg_we && (state == IDLE) && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign err_nxt = cfg_we && !cfg_ok;

    // Bits advance the window only while scanning; an abort on the same edge drops the bit.
    assign shift = (state == SCAN) && x_valid && !abort;

    // Window restarts on every entry to SCAN and after a hit when matches may not overlap.
    assign clr = ((state != SCAN) && start && !abort) || (hit && !ovl_q);

    seq_window_cmp #(
        .MAX_LEN (MAX_LEN)
    ) u_win (
        .clk     (clk),
        .reset   (reset),
        .shift   (shift),
        .clr     (clr),
        .x       (x),
        .pattern (pat_q),
        .len     (len_q),
        .hit     (hit)
    );

    // Next state, next count and match pulse; abort outranks start, start in SCAN is ignored.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = match_cnt;
        match_nxt = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nxt = SCAN;
                        cnt_nxt   = '0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        match_nxt = 1'b1;
                        if (lim_q == '0) begin
                            if (!(&match_cnt)) begin
                                cnt_nxt = match_cnt + 1'b1;
                            end
                        end else begin
                            cnt_nxt = match_cnt + 1'b1;
                            if (cnt_nxt == lim_q) begin
                                state_nxt = DONE;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Configuration registers; the scan keeps whatever was last accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pat_q <= '0;
            len_q <= LEN_W'(1);
            ovl_q <= 1'b1;
            lim_q <= '0;
        end else if (cfg_ok) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            ovl_q <= cfg_overlap;
            lim_q <= cfg_limit;
        end
    end

    // Registered status outputs: match pulse, running count, config reject pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            match     <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            match     <= match_nxt;
            match_cnt <= cnt_nxt;
            cfg_err   <= err_nxt;
        end
    end

    assign busy = (state == SCAN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: vector table, directed corner sequences, random vs reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_limit;
    logic               cfg_err;
    logic               start;
    logic               abort;
    logic               x_valid;
    logic               x;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;

    seq_detect_ctrl #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_limit   (cfg_limit),
        .cfg_err     (cfg_err),
        .start       (start),
        .abort       (abort),
        .x_valid     (x_valid),
        .x           (x),
        .match       (match),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the history of bits received since the last restart, matched from its tail.
    int   m_state;   // 0 idle, 1 scanning, 2 done
    int   m_pat;
    int   m_len;
    bit   m_ovl;
    int   m_lim;
    int   m_cnt;
    bit   m_match;
    bit   m_err;
    bit   hist[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit tail_match();
        int n;
        n = hist.size();
        if (n < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            // the oldest bit of the tail corresponds to pattern[len-1]
            if (hist[n - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        if (!reset) begin
            m_state = 0; m_pat = 0; m_len = 1; m_ovl = 1'b1; m_lim = 0;
            m_cnt = 0; m_match = 1'b0; m_err = 1'b0;
            hist.delete();
            return;
        end
        m_err = cfg_we && !(m_state == 0 && cfg_len >= 1 && cfg_len <= MAX_LEN);
        if (cfg_we && !m_err) begin
            m_pat = cfg_pattern; m_len = cfg_len; m_ovl = cfg_overlap; m_lim = cfg_limit;
        end
        m_match = 1'b0;
        if (abort) begin
            m_state = 0;
        end else if (m_state == 1) begin
            if (x_valid) begin
                hist.push_back(x);
                if (hist.size() > 32) void'(hist.pop_front());
                if (tail_match()) begin
                    m_match = 1'b1;
                    if (m_lim == 0) m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
                    else m_cnt = m_cnt + 1;
                    if (!m_ovl) hist.delete();
                    if (m_lim != 0 && m_cnt == m_lim) m_state = 2;
                end
            end
        end else if (start) begin
            m_state = 1;
            m_cnt = 0;
            hist.delete();
        end
    endtask

    // One clock: outputs sampled after the edge, the model advances on the same pre-edge inputs.
    task automatic step(input bit use_model);
        @(posedge clk);
        #1;
        model_step();
        if (use_model) begin
            chk("match",     int'(match),     int'(m_match));
            chk("match_cnt", int'(match_cnt), m_cnt);
            chk("busy",      int'(busy),      int'(m_state == 1));
            chk("done",      int'(done),      int'(m_state == 2));
            chk("cfg_err",   int'(cfg_err),   int'(m_err));
        end
    endtask

    task automatic clear_ctl();
        cfg_we = 1'b0; start = 1'b0; abort = 1'b0; x_valid = 1'b0; x = 1'b0;
    endtask

    task automatic do_cfg(input int pat, input int len, input bit ovl, input int lim);
        cfg_pattern = MAX_LEN'(pat); cfg_len = LEN_W'(len); cfg_overlap = ovl; cfg_limit = CNT_W'(lim);
        cfg_we = 1'b1;
        step(1);
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1; step(1); abort = 1'b0;
    endtask

    // Sends n bits MSB-first, with gap idle cycles after each bit.
    task automatic send_bits(input logic [15:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            x_valid = 1'b1; x = bits[i];
            step(1);
            x_valid = 1'b0;
            repeat (gap) step(1);
        end
    endtask

    typedef struct {
        bit we, st, ab, v, xb;
        bit e_match;
        int e_cnt;
        bit e_busy, e_done;
    } vec_t;

    vec_t tbl[10];

    initial begin
        clear_ctl();
        cfg_pattern = '0; cfg_len = LEN_W'(1); cfg_overlap = 1'b0; cfg_limit = '0;
        reset = 1'b0;

        // Reset state
        step(0);
        step(0);
        chk("rst_match", int'(match), 0);
        chk("rst_cnt",   int'(match_cnt), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_err",   int'(cfg_err), 0);
        reset = 1'b1;

        // Vector table: pattern 1011, len 4, overlap, unlimited; stream 1011011
        //          we st ab v  x   match cnt busy done
        tbl[0] = '{1, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 0, 0,  0, 0, 1, 0};
        tbl[2] = '{0, 0, 0, 1, 1,  0, 0, 1, 0};
        tbl[3] = '{0, 0, 0, 1, 0,  0, 0, 1, 0};
        tbl[4] = '{0, 0, 0, 1, 1,  0, 0, 1, 0};
        tbl[5] = '{0, 0, 0, 1, 1,  1, 1, 1, 0};
        tbl[6] = '{0, 0, 0, 1, 0,  0, 1, 1, 0};
        tbl[7] = '{0, 0, 0, 1, 1,  0, 1, 1, 0};
        tbl[8] = '{0, 0, 0, 1, 1,  1, 2, 1, 0};
        tbl[9] = '{0, 0, 0, 0, 0,  0, 2, 1, 0};
        cfg_pattern = 8'b0000_1011; cfg_len = LEN_W'(4); cfg_overlap = 1'b1; cfg_limit = '0;
        for (int i = 0; i < 10; i++) begin
            cfg_we = tbl[i].we; start = tbl[i].st; abort = tbl[i].ab;
            x_valid = tbl[i].v; x = tbl[i].xb;
            step(0);
            chk($sformatf("tbl%0d_match", i), int'(match),     int'(tbl[i].e_match));
            chk($sformatf("tbl%0d_cnt", i),   int'(match_cnt), tbl[i].e_cnt);
            chk($sformatf("tbl%0d_busy", i),  int'(busy),      int'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_done", i),  int'(done),      int'(tbl[i].e_done));
        end
        clear_ctl();

        // Non-overlapping: same stream yields one match
        do_abort();
        do_cfg(8'b1011, 4, 1'b0, 0);
        do_start();
        send_bits(16'b1011011, 7, 0);
        step(1);
        chk("novl_cnt", int'(match_cnt), 1);

        // Limit 2: done the cycle after bit 7, later bits ignored
        do_abort();
        do_cfg(8'b1011, 4, 1'b1, 2);
        do_start();
        send_bits(16'b1011011, 7, 0);
        chk("lim_done_after7", int'(done), 1);
        chk("lim_match_after7", int'(match), 1);
        send_bits(16'b011, 3, 0);
        chk("lim_done", int'(done), 1);
        chk("lim_cnt", int'(match_cnt), 2);

        // Gaps of 3 idle cycles between bits
        do_abort();
        do_cfg(8'b1011, 4, 1'b1, 0);
        do_start();
        send_bits(16'b1011, 4, 3);
        chk("gap_cnt", int'(match_cnt), 1);

        // Rejected configuration: len 0 in IDLE, then any write during SCAN
        do_abort();
        do_cfg(8'b1111, 0, 1'b1, 0);
        chk("err_len0", int'(cfg_err), 1);
        step(1);
        chk("err_pulse_end", int'(cfg_err), 0);
        do_start();
        do_cfg(8'b0000, 2, 1'b1, 0);
        chk("err_scan", int'(cfg_err), 1);
        send_bits(16'b1011, 4, 0);
        chk("err_cfg_kept", int'(match_cnt), 1);

        // Abort mid-pattern: no match, count held; restart clears it
        do_start();
        send_bits(16'b101, 3, 0);
        abort = 1'b1; x_valid = 1'b1; x = 1'b1;
        step(1);
        clear_ctl();
        chk("abort_nomatch", int'(match), 0);
        chk("abort_idle", int'(busy), 0);
        do_start();
        send_bits(16'b1011, 4, 0);
        chk("restart_cnt", int'(match_cnt), 1);

        // Reset mid-pattern: config returns to defaults
        send_bits(16'b101, 3, 0);
        reset = 1'b0; x_valid = 1'b1; x = 1'b1;
        step(1);
        reset = 1'b1; clear_ctl();
        chk("rstmid_match", int'(match), 0);
        chk("rstmid_cnt", int'(match_cnt), 0);

        // Saturation at all-ones with unlimited count
        do_cfg(8'b1, 1, 1'b1, 0);
        do_start();
        x_valid = 1'b1; x = 1'b1;
        repeat (260) step(1);
        clear_ctl();
        chk("sat_cnt", int'(match_cnt), 255);

        // Longest pattern, non-overlapping
        do_abort();
        do_cfg(8'b1001_0110, 8, 1'b0, 0);
        do_start();
        send_bits(16'b1001_0110_1001_0110, 16, 0);
        chk("len8_cnt", int'(match_cnt), 2);

        // Random episodes against the reference model
        for (int ep = 0; ep < 40; ep++) begin
            do_abort();
            do_cfg($urandom_range(0, 255),
                   ($urandom_range(0, 9) == 0) ? $urandom_range(0, 9) : $urandom_range(1, 4),
                   1'($urandom_range(0, 1)), $urandom_range(0, 4));
            do_start();
            for (int c = 0; c < 60; c++) begin
                int r;
                r = $urandom_range(0, 99);
                x_valid = ($urandom_range(0, 3) != 0);
                x = 1'($urandom_range(0, 1));
                abort = (r < 2);
                start = (r >= 2 && r < 5);
                cfg_we = (r >= 5 && r < 8);
                cfg_pattern = MAX_LEN'($urandom_range(0, 255));
                cfg_len = LEN_W'($urandom_range(0, 9));
                cfg_overlap = 1'($urandom_range(0, 1));
                cfg_limit = CNT_W'($urandom_range(0, 4));
                reset = (r != 99);
                step(1);
                reset = 1'b1;
            end
            clear_ctl();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
